// File: rtl/m2m_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : m2m_pkg
//  Description : Shared types and constants for the memory-to-memory
//                transfer controller (state encoding, default widths, depth).
//  Revision    : 1.0 - initial release
// ============================================================================
package m2m_pkg;

  // Default datapath geometry
  localparam int M2M_DATA_W = 8;
  localparam int M2M_ADDR_W = 3;

  // Controller states, binary encoded
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Plain-vector aliases so state registers stay legacy-compatible logic
  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_CLEAR = CLEAR;
  localparam logic [2:0] ST_READ  = READ;
  localparam logic [2:0] ST_WRITE = WRITE;
  localparam logic [2:0] ST_DONE  = DONE;

  // Transfer length for a given address width
  function automatic int m2mDepth(input int addrW);
    return 1 << addrW;
  endfunction

endpackage : m2m_pkg
`default_nettype wire

// File: rtl/m2m_transfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : m2m_transfer_ctrl
//  Description : Control FSM copying memory A into memory B word by word.
//                Drives counterA/counterB clear and increment, memory B
//                write strobe and data. All control outputs are registered.
//  Config      : M2M_COMPARE_EN - when defined, a word is only written to B
//                if it is the first word of the transfer or strictly greater
//                (unsigned) than the last word written.
//  Revision    : 1.0 - initial release
// ============================================================================
module m2m_transfer_ctrl
  import m2m_pkg::*;
#(
  parameter int DATA_W = M2M_DATA_W,
  parameter int ADDR_W = M2M_ADDR_W
) (
  input  logic              clock,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [DATA_W-1:0] DataA,
  input  logic [ADDR_W-1:0] AddrA,
  output logic              ClrCnt,
  output logic              IncA,
  output logic              IncB,
  output logic              WEB,
  output logic [DATA_W-1:0] DataB,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W:0]   WrCount
);

  localparam int                c_DEPTH     = m2mDepth(ADDR_W);
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(c_DEPTH - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_nextState;
  logic [DATA_W-1:0] r_dataQ;
  logic [ADDR_W:0]   r_wrCount;
  logic              w_keepNext;

  logic r_clrCnt;
  logic r_incA;
  logic r_incB;
  logic r_web;
  logic r_busy;
  logic r_done;

`ifdef M2M_COMPARE_EN
  logic [DATA_W-1:0] r_lastQ;
  logic              r_firstQ;

  // Decided while in READ, for the word about to be latched into data_q
  assign w_keepNext = r_firstQ | (DataA > r_lastQ);

  // Track the last word written and whether anything has been written yet
  always_ff @(posedge clock) begin
    if (!Reset_n) begin
      r_lastQ  <= '0;
      r_firstQ <= 1'b0;
    end else if (r_state == ST_CLEAR) begin
      r_firstQ <= 1'b1;
    end else if (r_state == ST_WRITE && r_web) begin
      r_lastQ  <= r_dataQ;
      r_firstQ <= 1'b0;
    end
  end
`else
  assign w_keepNext = 1'b1;
`endif

  // Next-state decode; terminal count taken from counterA before it wraps
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  w_nextState = Start ? ST_CLEAR : ST_IDLE;
      ST_CLEAR: w_nextState = ST_READ;
      ST_READ:  w_nextState = ST_WRITE;
      ST_WRITE: w_nextState = (AddrA == c_LAST_ADDR) ? ST_DONE : ST_READ;
      ST_DONE:  w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // State register, read-data latch and written-word counter
  always_ff @(posedge clock) begin
    if (!Reset_n) begin
      r_state   <= ST_IDLE;
      r_dataQ   <= '0;
      r_wrCount <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_READ) begin
        r_dataQ <= DataA;
      end
      if (r_state == ST_IDLE && Start) begin
        r_wrCount <= '0;
      end else if (r_state == ST_WRITE && r_web) begin
        r_wrCount <= r_wrCount + 1'b1;
      end
    end
  end

  // Outputs registered from the next state so each is a clean flop output
  always_ff @(posedge clock) begin
    if (!Reset_n) begin
      r_clrCnt <= 1'b0;
      r_incA   <= 1'b0;
      r_incB   <= 1'b0;
      r_web    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_clrCnt <= (w_nextState == ST_CLEAR);
      r_incA   <= (w_nextState == ST_WRITE);
      r_incB   <= (w_nextState == ST_WRITE) && w_keepNext;
      r_web    <= (w_nextState == ST_WRITE) && w_keepNext;
      r_busy   <= (w_nextState == ST_CLEAR) || (w_nextState == ST_READ) ||
                  (w_nextState == ST_WRITE);
      r_done   <= (w_nextState == ST_DONE);
    end
  end

  assign ClrCnt  = r_clrCnt;
  assign IncA    = r_incA;
  assign IncB    = r_incB;
  assign WEB     = r_web;
  assign DataB   = r_dataQ;
  assign Busy    = r_busy;
  assign Done    = r_done;
  assign WrCount = r_wrCount;

endmodule : m2m_transfer_ctrl
`default_nettype wire

// File: tb/tb_m2m_transfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m2m_transfer_ctrl
//  Description : Self-checking bench for m2m_transfer_ctrl with behavioural
//                counterA/counterB and memories A/B around the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_m2m_transfer_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic              clock = 1'b0;
  logic              Reset_n = 1'b0;
  logic              Start = 1'b0;
  logic [DATA_W-1:0] DataA;
  logic [ADDR_W-1:0] AddrA;
  logic              ClrCnt, IncA, IncB, WEB, Busy, Done;
  logic [DATA_W-1:0] DataB;
  logic [ADDR_W:0]   WrCount;

  logic [DATA_W-1:0] memA [DEPTH];
  logic [DATA_W-1:0] memB [DEPTH];
  logic [ADDR_W-1:0] cntA = '0;
  logic [ADDR_W-1:0] cntB = '0;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clock = ~clock;

  m2m_transfer_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock   (clock),
    .Reset_n (Reset_n),
    .Start   (Start),
    .DataA   (DataA),
    .AddrA   (AddrA),
    .ClrCnt  (ClrCnt),
    .IncA    (IncA),
    .IncB    (IncB),
    .WEB     (WEB),
    .DataB   (DataB),
    .Busy    (Busy),
    .Done    (Done),
    .WrCount (WrCount)
  );

  // Surrounding datapath: two address counters and the two memories
  assign AddrA = cntA;
  assign DataA = memA[cntA];

  always @(posedge clock) begin
    if (ClrCnt) cntA <= '0;
    else if (IncA) cntA <= cntA + 1'b1;
    if (ClrCnt) cntB <= '0;
    else if (IncB) cntB <= cntB + 1'b1;
    if (WEB) memB[cntB] <= DataB;
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] strobes();
    return {ClrCnt, IncA, IncB, WEB, Busy, Done};
  endfunction

  // One transfer, checked cycle by cycle. k counts cycles after the edge that
  // samples Start. resetAt>0 pulls Reset_n low at the end of cycle resetAt.
  task automatic runTransfer(input bit holdStart, input int resetAt);
    bit                kept [DEPTH];
    logic [DATA_W-1:0] keptWords [$];
    logic [DATA_W-1:0] last;
    bit                first;
    int                written;
    int                wi;
    logic [5:0]        expStrobe;

    // Reference: which words survive the copy rule
    first = 1'b1;
    last  = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef M2M_COMPARE_EN
      kept[i] = first || (memA[i] > last);
`else
      kept[i] = 1'b1;
`endif
      if (kept[i]) begin
        keptWords.push_back(memA[i]);
        last  = memA[i];
        first = 1'b0;
      end
    end

    @(negedge clock);
    Start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (resetAt != 0 && k == resetAt + 1) begin
        checkVal("reset strobes", {26'd0, strobes()}, 32'd0);
        checkVal("reset WrCount", {27'd0, WrCount}, 32'd0);
        checkVal("reset DataB", {24'd0, DataB}, 32'd0);
        Reset_n = 1'b1;
        Start   = 1'b0;
        return;
      end
      wi = (k - 3) / 2;
      written = 0;
      for (int i = 0; i < DEPTH; i++)
        if (kept[i] && (3 + 2 * i) < k) written++;
      expStrobe[5] = (k == 1);
      expStrobe[4] = (k >= 3) && (k <= 17) && (k % 2 == 1);
      expStrobe[3] = expStrobe[4] && kept[wi];
      expStrobe[2] = expStrobe[3];
      expStrobe[1] = (k >= 1) && (k <= 17);
      expStrobe[0] = (k == 18);
      checkVal($sformatf("strobes k=%0d", k), {26'd0, strobes()}, {26'd0, expStrobe});
      checkVal($sformatf("WrCount k=%0d", k), {27'd0, WrCount}, written);
      if (expStrobe[3])
        checkVal($sformatf("DataB k=%0d", k), {24'd0, DataB}, {24'd0, memA[wi]});
      if (k >= 2 && k <= 17)
        checkVal($sformatf("AddrA k=%0d", k), {29'd0, AddrA}, (k - 2) / 2);
      if (k == 18)
        checkVal("AddrA wrap", {29'd0, AddrA}, 32'd0);
      if (resetAt == k) Reset_n = 1'b0;
      if (!holdStart || k >= 19) Start = 1'b0;
    end
    for (int j = 0; j < keptWords.size(); j++)
      checkVal($sformatf("memB[%0d]", j), {24'd0, memB[j]}, {24'd0, keptWords[j]});
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      memA[i] = '0;
      memB[i] = '0;
    end

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkVal("por strobes", {26'd0, strobes()}, 32'd0);
    checkVal("por WrCount", {27'd0, WrCount}, 32'd0);
    checkVal("por DataB", {24'd0, DataB}, 32'd0);
    Reset_n = 1'b1;

    // Idle quiet
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      checkVal("idle strobes", {26'd0, strobes()}, 32'd0);
    end

    // Basic ascending copy
    for (int i = 0; i < DEPTH; i++) memA[i] = 8'h10 + 8'(i);
    runTransfer(1'b0, 0);

    // Mixed pattern that exercises the conditional copy
    memA[0] = 5; memA[1] = 3; memA[2] = 7;  memA[3] = 7;
    memA[4] = 9; memA[5] = 1; memA[6] = 10; memA[7] = 2;
    runTransfer(1'b0, 0);

    // Start held high for the whole transfer
    for (int i = 0; i < DEPTH; i++) memA[i] = 8'($urandom_range(0, 255));
    runTransfer(1'b1, 0);

    // Reset during the WRITE of word 3, then a clean restart
    for (int i = 0; i < DEPTH; i++) memA[i] = 8'($urandom_range(0, 255));
    runTransfer(1'b0, 9);
    runTransfer(1'b0, 0);

    // Randomized transfers, small value range to create equal/descending runs
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < DEPTH; i++)
        memA[i] = (t % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      runTransfer(($urandom_range(0, 1) == 1), 0);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule : tb_m2m_transfer_ctrl
`default_nettype wire

// File: doc/m2m_transfer_ctrl.md
# m2m_transfer_ctrl

Control FSM for the memory-to-memory transfer datapath. On a Start pulse it clears the A/B address counters, then steps through memory A one word at a time. Each word is latched and written into memory B, with counterA and counterB advanced by IncA/IncB. It sits directly upstream of counterA/counterB (drives their increment and clear inputs) and beside both memories (drives WEB/DataB, consumes DataA).

## Interface
- DATA_W, 8, memory word width
- ADDR_W, 3, address width; transfer length DEPTH = 2**ADDR_W (8)

- clock  in  1  rising-edge clock, shared with counters and memories
- Reset_n  in  1  synchronous active-low reset
- Start  in  1  request a transfer; sampled only in IDLE
- DataA  in  DATA_W  memory A read data at current AddrA (combinational read)
- AddrA  in  ADDR_W  counterA output, used for terminal-count detection
- ClrCnt  out  1  one-cycle clear pulse to counterA/counterB Reset inputs
- IncA  out  1  advance counterA
- IncB  out  1  advance counterB
- WEB  out  1  memory B write enable
- DataB  out  DATA_W  memory B write data
- Busy  out  1  high from CLEAR through WRITE
- Done  out  1  one-cycle completion pulse
- WrCount  out  ADDR_W+1  words written to B in the last/current transfer

## Operation
- States: IDLE, CLEAR, READ, WRITE, DONE (binary encoded).
- IDLE: all strobes 0. If Start=1, go to CLEAR and zero WrCount.
- CLEAR: ClrCnt=1, then go to READ.
- READ: latch DataA into data_q, then go to WRITE.
- WRITE:
  - WEB=1, DataB=data_q, IncA=1, IncB=1, WrCount+1.
  - If AddrA == DEPTH-1, go to DONE; otherwise go to READ.
- DONE: Done=1, then go to IDLE.
- DataB is driven from data_q in every state. It is meaningful only while WEB=1.
- Start outside IDLE is ignored; no queuing.
- AddrA wraps to 0 on the final IncA. This is harmless because the FSM leaves WRITE on that same cycle.
- WrCount saturates naturally at DEPTH (ADDR_W+1 bits). It holds its value until the next Start.

## Timing
- Reset (Reset_n=0 at a clock edge):
  - state=IDLE; data_q=0, WrCount=0.
  - All outputs 0: ClrCnt, IncA, IncB, WEB, Busy, Done, DataB.
  - This holds even mid-transfer. Counters are not cleared by controller reset; the next CLEAR clears them.
- Start sampled at edge N: CLEAR during cycle N+1.
- READ/WRITE pairs then occupy cycles N+2 … N+2*DEPTH+1.
- Done is high in cycle N+2*DEPTH+2 (N+18 for DEPTH=8). IDLE follows in the next cycle.
- Back-to-back: a Start held high during DONE is not seen. Start must be high in an IDLE cycle.
- ClrCnt drives the counters' asynchronous clear. It is a registered (glitch-free) output.
- The first READ sees AddrA=0.

## Configuration
- Macro: M2M_COMPARE_EN.
- Undefined: every word is copied; WrCount=DEPTH at DONE.
- Defined: conditional copy. A register last_q holds the last word written; a flag first_q is set in CLEAR.
  - In WRITE, WEB, IncB and the WrCount increment assert only if first_q=1 or data_q > last_q (unsigned, strict).
  - On a write, last_q is updated and first_q is cleared.
  - IncA and the state sequence are unchanged, so timing is identical.

## Structure
- Package m2m_pkg holds:
  - state enum (IDLE, CLEAR, READ, WRITE, DONE)
  - default DATA_W and ADDR_W constants
  - DEPTH derivation
- Single flat module; no sub-module. The comparator is one inline expression under the macro. counterA/counterB stay separate instances at the top level.

## Test plan
- Reset: Reset_n low mid-transfer (during WRITE of word 3) -> next cycle all outputs 0, state IDLE; next Start restarts from CLEAR with ClrCnt=1.
- Basic copy: memory A = 0x10..0x17, Start pulse at cycle 0 -> WEB high on cycles 3,5,…,17 with DataB 0x10..0x17; Done at cycle 18; WrCount=8.
- Start ignored: Start held high throughout a transfer -> no re-entry into CLEAR until IDLE; exactly one Done per IDLE→Start.
- Terminal count: check AddrA steps 0..7 then wraps to 0 on the final IncA, with the FSM in DONE on the next cycle -> no ninth WEB.
- Compare (M2M_COMPARE_EN): A = 5,3,7,7,9,1,10,2 -> B receives 5,7,9,10 at B addrs 0..3; WrCount=4; Done still at cycle 18.
- Idle quiet: Start=0 for 50 cycles after reset -> all strobes remain 0, Busy=0.
